// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, synchronous-read memory between the
// fetch port (I, read-only) and the load/store port (D, read/write).
// D has fixed priority; a saturating starvation counter hands the slot to I
// once it has been blocked by D for STARVE_LIMIT consecutive cycles.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [WIDTH-1:0]      i_rdata,
  // load/store port
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WIDTH/8-1:0]    d_we,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WIDTH-1:0]      d_rdata,
  // memory side
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [WIDTH/8-1:0]    mem_we,
  output logic                  mem_re,
  input  logic [WIDTH-1:0]      mem_rdata
);

  localparam int unsigned BW = WIDTH / 8;
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  logic          resp_i_q, resp_i_d;
  logic          resp_d_q, resp_d_d;
  logic          starved;
  logic          d_is_rd;

  assign d_is_rd = ~|d_we;

  // Per-cycle grant: D wins unless I has been starved to the limit
  always_comb begin
    starved = i_req && (starve_q == LIMIT);
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    if (!rst) begin
      if (d_req && !starved) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // Steer the granted requester onto the memory port; idle drives zeros
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = BW'(0);
    mem_re    = 1'b0;
    if (i_gnt) begin
      mem_addr = i_addr;
      mem_re   = 1'b1;
    end else if (d_gnt) begin
      mem_addr = d_addr;
      if (d_is_rd) begin
        mem_re = 1'b1;
      end else begin
        mem_we    = d_we;
        mem_wdata = d_wdata;
      end
    end
  end

  // Next-state for response tracking and the starvation counter
  always_comb begin
    resp_i_d = i_gnt;
    resp_d_d = d_gnt && d_is_rd;
    starve_d = starve_q;
    if (!i_req || i_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != LIMIT)) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // State registers; reset drops any read response in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_i_q <= 1'b0;
      resp_d_q <= 1'b0;
      starve_q <= '0;
    end else begin
      resp_i_q <= resp_i_d;
      resp_d_q <= resp_d_d;
      starve_q <= starve_d;
    end
  end

  assign i_rvalid = resp_i_q;
  assign d_rvalid = resp_d_q;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table for the documented scenarios,
// then randomized traffic checked against a transaction-level reference model
// with its own shadow memory.
module tb_mem_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 64;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned NVEC  = 27;

  localparam logic [AW-1:0] A4  = 10'h004;
  localparam logic [AW-1:0] A10 = 10'h010;
  localparam logic [AW-1:0] A20 = 10'h020;
  localparam logic [DW-1:0] M4  = 64'hDEAD_BEEF_0000_0013;
  localparam logic [DW-1:0] M10 = 64'hC0DE_0010_5A5A_0010;
  localparam logic [DW-1:0] M20 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [DW-1:0] WD  = 64'h1122_3344_5566_7788;
  localparam logic [DW-1:0] M20W = 64'hAAAA_BBBB_5566_7788;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [7:0]    d_we;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Power-on memory image, shared by the memory model and the shadow copy
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == A4)  return M4;
    if (a == A20) return M20;
    return {32'hC0DE_0000 | 32'(a), 32'h5A5A_0000 | 32'(a)};
  endfunction

  // Synchronous-read, byte-writable memory attached to the DUT
  logic [DW-1:0] tbmem [1024];
  bit            wr    [1024];
  always @(posedge clk) begin
    logic [DW-1:0] base;
    if (mem_re) mem_rdata <= wr[mem_addr] ? tbmem[mem_addr] : init_word(mem_addr);
    if (|mem_we) begin
      base = wr[mem_addr] ? tbmem[mem_addr] : init_word(mem_addr);
      for (int b = 0; b < 8; b++)
        if (mem_we[b]) base[b*8 +: 8] = mem_wdata[b*8 +: 8];
      tbmem[mem_addr] <= base;
      wr[mem_addr]    <= 1'b1;
    end
  end

  typedef struct packed {
    logic          rst;
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr;
    logic [7:0]    dwe;
    logic [AW-1:0] da;
    logic [DW-1:0] dwd;
    logic          eig, edg, eirv, edrv, chk;
    logic [DW-1:0] edata;
  } vec_t;

  function automatic vec_t row(input logic r, input logic ir, input logic [AW-1:0] ia,
                               input logic dr, input logic [7:0] dwe, input logic [AW-1:0] da,
                               input logic [DW-1:0] dwd, input logic eig, input logic edg,
                               input logic eirv, input logic edrv, input logic chk,
                               input logic [DW-1:0] edata);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.eig = eig; v.edg = edg; v.eirv = eirv; v.edrv = edrv; v.chk = chk; v.edata = edata;
    return v;
  endfunction

  // Reference model: shadow memory, cycles I has waited, pending responses
  logic [DW-1:0] ref_mem [1024];
  int            m_wait;
  bit            m_ri, m_rd;
  logic [DW-1:0] m_data;
  bit            last_ig, last_dg;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // One cycle: drive, compare against model (and table row if given), advance model
  task automatic step(input vec_t v, input bit use_tbl);
    bit eig, edg, erd;
    rst = v.rst; i_req = v.ir; i_addr = v.ia;
    d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
    if (v.rst) begin m_ri = 0; m_rd = 0; m_wait = 0; end
    #2;
    edg = !v.rst && v.dr && !(v.ir && m_wait >= int'(LIMIT));
    eig = !v.rst && v.ir && !edg;
    erd = edg && (v.dwe == 8'h00);
    chk("i_gnt", 64'(i_gnt), 64'(eig));
    chk("d_gnt", 64'(d_gnt), 64'(edg));
    chk("mem_re", 64'(mem_re), 64'(eig || erd));
    chk("mem_we", 64'(mem_we), 64'(edg ? v.dwe : 8'h00));
    chk("mem_addr", 64'(mem_addr), 64'(eig ? v.ia : (edg ? v.da : 10'h000)));
    if (edg && !erd) chk("mem_wdata", mem_wdata, v.dwd);
    if (!eig && !edg) chk("mem_wdata_idle", mem_wdata, 64'h0);
    chk("i_rvalid", 64'(i_rvalid), 64'(m_ri));
    chk("d_rvalid", 64'(d_rvalid), 64'(m_rd));
    if (m_ri) chk("i_rdata", i_rdata, m_data);
    if (m_rd) chk("d_rdata", d_rdata, m_data);
    if (use_tbl) begin
      chk("tbl_i_gnt", 64'(i_gnt), 64'(v.eig));
      chk("tbl_d_gnt", 64'(d_gnt), 64'(v.edg));
      chk("tbl_i_rvalid", 64'(i_rvalid), 64'(v.eirv));
      chk("tbl_d_rvalid", 64'(d_rvalid), 64'(v.edrv));
      if (v.chk) chk("tbl_rdata", v.eirv ? i_rdata : d_rdata, v.edata);
    end
    last_ig = eig; last_dg = edg;
    if (!v.rst) begin
      m_ri = eig;
      m_rd = erd;
      if (eig) m_data = ref_mem[v.ia];
      else if (erd) m_data = ref_mem[v.da];
      if (edg && !erd)
        for (int b = 0; b < 8; b++)
          if (v.dwe[b]) ref_mem[v.da][b*8 +: 8] = v.dwd[b*8 +: 8];
      if (v.ir && edg) m_wait = (m_wait >= int'(LIMIT)) ? int'(LIMIT) : m_wait + 1;
      else m_wait = 0;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [NVEC];

  initial begin
    vec_t v;
    vec_t both, idle;
    bit   ir, dr;
    logic [AW-1:0] ia, da;
    logic [7:0]    dwe;
    logic [DW-1:0] dwd;

    rst = 1'b1; i_req = 0; d_req = 0; i_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
    for (int a = 0; a < 1024; a++) ref_mem[a] = init_word(AW'(a));
    m_wait = 0; m_ri = 0; m_rd = 0; m_data = '0;

    tbl[0]  = row(1, 1, A4, 1, 8'h00, A10, 64'h0, 0, 0, 0, 0, 0, 64'h0);
    tbl[1]  = tbl[0];
    tbl[2]  = row(0, 1, A4, 1, 8'h00, A10, 64'h0, 0, 1, 0, 0, 0, 64'h0);
    tbl[3]  = row(0, 1, A4, 0, 8'h00, 10'h0, 64'h0, 1, 0, 0, 1, 1, M10);
    tbl[4]  = row(0, 0, 10'h0, 0, 8'h00, 10'h0, 64'h0, 0, 0, 1, 0, 1, M4);
    tbl[5]  = row(0, 1, A4, 0, 8'h00, 10'h0, 64'h0, 1, 0, 0, 0, 0, 64'h0);
    tbl[6]  = tbl[4];
    tbl[7]  = row(0, 1, A4, 1, 8'h00, A10, 64'h0, 0, 1, 0, 0, 0, 64'h0);
    tbl[8]  = row(0, 1, A4, 1, 8'h00, A10, 64'h0, 0, 1, 0, 1, 1, M10);
    tbl[9]  = tbl[8];
    tbl[10] = tbl[8];
    tbl[11] = row(0, 1, A4, 1, 8'h00, A10, 64'h0, 1, 0, 0, 1, 1, M10);
    tbl[12] = row(0, 1, A4, 1, 8'h00, A10, 64'h0, 0, 1, 1, 0, 1, M4);
    tbl[13] = row(0, 0, 10'h0, 0, 8'h00, 10'h0, 64'h0, 0, 0, 0, 1, 1, M10);
    tbl[14] = row(0, 0, 10'h0, 1, 8'h0F, A20, WD, 0, 1, 0, 0, 0, 64'h0);
    tbl[15] = row(0, 0, 10'h0, 1, 8'h00, A20, 64'h0, 0, 1, 0, 0, 0, 64'h0);
    tbl[16] = row(0, 0, 10'h0, 0, 8'h00, 10'h0, 64'h0, 0, 0, 0, 1, 1, M20W);
    tbl[17] = tbl[7];
    tbl[18] = tbl[8];
    tbl[19] = tbl[8];
    tbl[20] = tbl[0];
    tbl[21] = tbl[7];
    tbl[22] = tbl[8];
    tbl[23] = tbl[8];
    tbl[24] = tbl[8];
    tbl[25] = tbl[11];
    tbl[26] = tbl[4];

    @(posedge clk);
    #1;
    for (int k = 0; k < int'(NVEC); k++) step(tbl[k], 1'b1);

    // Randomized traffic: requesters hold until granted, occasionally withdraw
    ir = 0; dr = 0; ia = '0; da = '0; dwe = '0; dwd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!(ir && !last_ig && $urandom_range(0, 19) != 0)) begin
        ir = ($urandom_range(0, 2) != 0);
        ia = AW'($urandom_range(0, 15));
      end
      if (!(dr && !last_dg && $urandom_range(0, 19) != 0)) begin
        dr  = ($urandom_range(0, 2) != 0);
        da  = ($urandom_range(0, 7) == 0) ? A20 : AW'($urandom_range(0, 15));
        dwe = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(1, 255));
        dwd = {$urandom, $urandom};
      end
      v = row(($urandom_range(0, 149) == 0), ir, ia, dr, dwe, da, dwd,
              0, 0, 0, 0, 0, 64'h0);
      step(v, 1'b0);
      if (v.rst) begin ir = 0; dr = 0; end
    end

    idle = row(0, 0, 10'h0, 0, 8'h00, 10'h0, 64'h0, 0, 0, 0, 0, 0, 64'h0);
    both = idle;
    step(idle, 1'b0);
    step(both, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
